// File: rtl/alu_multicycle.sv
// Multi-cycle MIPS-style ALU with valid/ready handshakes on input and output.
// Single-cycle ops (logic, add/sub, slt, lui, shifts) register in one edge;
// MUL (shift-add) and DIV (restoring) iterate WIDTH cycles on operand
// magnitudes, then a FIX cycle applies the sign correction.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          request handshake (in_ready is combinational)
//   alu_control, first,        opcode, signed operands A/B, shift amount
//   second, shamt
//   out_valid/out_ready        result handshake
//   result, result_hi          primary result, MUL high half / DIV remainder
//   zero, negative, overflow,  registered flags
//   cout, err
module alu_multicycle #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned SHAMT_W   = 5,
    parameter bit          MULDIV_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         alu_control,
    input  logic [WIDTH-1:0]   first,
    input  logic [WIDTH-1:0]   second,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [WIDTH-1:0]   result_hi,
    output logic               zero,
    output logic               negative,
    output logic               overflow,
    output logic               cout,
    output logic               err
);

    localparam int unsigned MSB  = WIDTH - 1;
    localparam int unsigned HALF = WIDTH / 2;
    localparam logic [SHAMT_W-1:0] LAST = SHAMT_W'(WIDTH - 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1001;
    localparam logic [3:0] OP_DIV = 4'b1010;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_SLL = 4'b1101;
    localparam logic [3:0] OP_SRA = 4'b1110;
    localparam logic [3:0] OP_LUI = 4'b1111;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

    state_e             state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;     // MUL high partial / DIV partial remainder
    logic [WIDTH-1:0]   lo_q, lo_d;       // MUL multiplier->low product / DIV dividend->quotient
    logic [WIDTH-1:0]   b_q, b_d;         // |B|
    logic [WIDTH-1:0]   a_q, a_d;         // original A, returned on divide by zero
    logic               is_div_q, is_div_d;
    logic               qneg_q, qneg_d;   // product/quotient negative
    logic               rneg_q, rneg_d;   // remainder negative (dividend sign)
    logic               dz_q, dz_d;

    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   res_q, res_d, hi_q, hi_d;
    logic               z_q, z_d, n_q, n_d, v_q, v_d, c_q, c_d, err_q, err_d;

    logic               accept;
    logic [WIDTH:0]     add_w, sub_w;
    logic               add_ov, sub_ov;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_sh, div_try;
    logic [2*WIDTH-1:0] prod_mag, prod;
    logic [WIDTH-1:0]   quo, rem;

    logic               ld, ld_v, ld_c, ld_err;
    logic [WIDTH-1:0]   ld_res, ld_hi;

    // Gated by rst_n so the block never advertises ready while held in reset.
    assign in_ready = rst_n & (state_q == S_IDLE) & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    // Single-cycle datapath shared by ADD/SUB/SLT.
    assign add_w  = {1'b0, first} + {1'b0, second};
    assign sub_w  = {1'b0, first} + {1'b0, ~second} + (WIDTH+1)'(1);
    assign add_ov = (first[MSB] == second[MSB]) & (add_w[MSB] != first[MSB]);
    assign sub_ov = (first[MSB] != second[MSB]) & (sub_w[MSB] != first[MSB]);

    // |MIN| wraps to MIN, which is the correct unsigned magnitude 2^(WIDTH-1).
    assign a_mag = first[MSB]  ? (WIDTH'(0) - first)  : first;
    assign b_mag = second[MSB] ? (WIDTH'(0) - second) : second;

    // One shift-add / restoring step per cycle.
    assign mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : (WIDTH+1)'(0));
    assign div_sh  = {acc_q, lo_q[MSB]};
    assign div_try = div_sh - {1'b0, b_q};

    // Sign correction applied in FIX.
    assign prod_mag = {acc_q, lo_q};
    assign prod     = qneg_q ? ((2*WIDTH)'(0) - prod_mag) : prod_mag;
    assign quo      = qneg_q ? (WIDTH'(0) - lo_q)  : lo_q;
    assign rem      = rneg_q ? (WIDTH'(0) - acc_q) : acc_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            lo_q        <= '0;
            b_q         <= '0;
            a_q         <= '0;
            is_div_q    <= 1'b0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            dz_q        <= 1'b0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            hi_q        <= '0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            v_q         <= 1'b0;
            c_q         <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            lo_q        <= lo_d;
            b_q         <= b_d;
            a_q         <= a_d;
            is_div_q    <= is_div_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            dz_q        <= dz_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            hi_q        <= hi_d;
            z_q         <= z_d;
            n_q         <= n_d;
            v_q         <= v_d;
            c_q         <= c_d;
            err_q       <= err_d;
        end
    end

    // Next-state, iteration and output-load logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        lo_d        = lo_q;
        b_d         = b_q;
        a_d         = a_q;
        is_div_d    = is_div_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        dz_d        = dz_q;
        out_valid_d = out_valid_q & ~out_ready;
        res_d       = res_q;
        hi_d        = hi_q;
        z_d         = z_q;
        n_d         = n_q;
        v_d         = v_q;
        c_d         = c_q;
        err_d       = err_q;
        ld          = 1'b0;
        ld_res      = '0;
        ld_hi       = '0;
        ld_v        = 1'b0;
        ld_c        = 1'b0;
        ld_err      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    ld = 1'b1;
                    case (alu_control)
                        OP_ADD: begin ld_res = add_w[MSB:0]; ld_v = add_ov; ld_c = add_w[WIDTH]; end
                        OP_SUB: begin ld_res = sub_w[MSB:0]; ld_v = sub_ov; ld_c = sub_w[WIDTH]; end
                        OP_AND: ld_res = first & second;
                        OP_OR:  ld_res = first | second;
                        OP_XOR: ld_res = first ^ second;
                        OP_NOR: ld_res = ~(first | second);
                        OP_SLT: ld_res = {{(WIDTH-1){1'b0}}, sub_w[MSB] ^ sub_ov};
                        OP_LUI: ld_res = {second[HALF-1:0], {HALF{1'b0}}};
                        OP_SLL: ld_res = second << shamt;
                        OP_SRL: ld_res = second >> shamt;
                        OP_SRA: ld_res = $signed(second) >>> shamt;
                        OP_MUL, OP_DIV: begin
                            if (MULDIV_EN) begin
                                ld       = 1'b0;
                                state_d  = (alu_control == OP_MUL) ? S_MUL : S_DIV;
                                is_div_d = (alu_control == OP_DIV);
                                cnt_d    = '0;
                                acc_d    = '0;
                                lo_d     = a_mag;
                                b_d      = b_mag;
                                a_d      = first;
                                qneg_d   = first[MSB] ^ second[MSB];
                                rneg_d   = first[MSB];
                                dz_d     = (second == '0);
                            end else begin
                                ld_err = 1'b1;
                            end
                        end
                        default: ld_err = 1'b1;
                    endcase
                end
            end
            S_MUL: begin
                acc_d = mul_sum[WIDTH:1];
                lo_d  = {mul_sum[0], lo_q[MSB:1]};
                cnt_d = cnt_q + SHAMT_W'(1);
                if (cnt_q == LAST) state_d = S_FIX;
            end
            S_DIV: begin
                if (!div_try[WIDTH]) begin
                    acc_d = div_try[MSB:0];
                    lo_d  = {lo_q[MSB-1:0], 1'b1};
                end else begin
                    acc_d = div_sh[MSB:0];
                    lo_d  = {lo_q[MSB-1:0], 1'b0};
                end
                cnt_d = cnt_q + SHAMT_W'(1);
                if (cnt_q == LAST) state_d = S_FIX;
            end
            S_FIX: begin
                ld      = 1'b1;
                state_d = S_IDLE;
                cnt_d   = '0;
                if (!is_div_q) begin
                    ld_res = prod[MSB:0];
                    ld_hi  = prod[2*WIDTH-1:WIDTH];
                end else if (dz_q) begin
                    ld_res = '1;
                    ld_hi  = a_q;
                    ld_err = 1'b1;
                end else begin
                    ld_res = quo;
                    ld_hi  = rem;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (ld) begin
            out_valid_d = 1'b1;
            res_d       = ld_res;
            hi_d        = ld_hi;
            z_d         = (ld_res == '0);
            n_d         = ld_res[MSB];
            v_d         = ld_v;
            c_d         = ld_c;
            err_d       = ld_err;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = res_q;
    assign result_hi = hi_q;
    assign zero      = z_q;
    assign negative  = n_q;
    assign overflow  = v_q;
    assign cout      = c_q;
    assign err       = err_q;

endmodule
